// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and IF/ID register, fetches over a req/valid handshake,
// honours stall and flush/redirect, and freezes on HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [15:0]          br_target,
    fetch_stage_if.master        imem,
    output logic [15:0]          pc,
    output logic [15:0]          ifid_instr,
    output logic [15:0]          ifid_pc_plus2,
    output logic                 ifid_valid,
    output logic                 halted
);

    typedef enum logic [1:0] {FETCH, REDIRECT, HALT} state_t;

    state_t      state, state_next;
    logic [15:0] pc_next, instr_next, pc_plus2_next;
    logic        valid_next;
    logic [15:0] pc_plus2;
    logic        accept;
    logic        is_hlt;

    assign pc_plus2 = pc + 16'd2;
    assign accept   = (state == FETCH) && imem.imem_valid && !stall && !flush;
    assign is_hlt   = (imem.imem_rdata[15:12] == HLT_OPCODE);

    assign imem.imem_req  = rst_n && (state == FETCH);
    assign imem.imem_addr = pc;
    assign halted         = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            ifid_instr    <= '0;
            ifid_pc_plus2 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            pc            <= pc_next;
            ifid_instr    <= instr_next;
            ifid_pc_plus2 <= pc_plus2_next;
            ifid_valid    <= valid_next;
        end
    end

    // Priority flush > stall > accept > bubble; REDIRECT always lasts one cycle.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = ifid_instr;
        pc_plus2_next = ifid_pc_plus2;
        valid_next    = ifid_valid;

        if (flush) begin
            valid_next = 1'b0;
            instr_next = '0;
            pc_next    = br_target;
            state_next = REDIRECT;
        end else begin
            if (state == REDIRECT) begin
                state_next = FETCH;
            end
            if (stall) begin
                valid_next = ifid_valid;
            end else if (accept) begin
                instr_next    = imem.imem_rdata;
                pc_plus2_next = pc_plus2;
                valid_next    = 1'b1;
                if (is_hlt) begin
                    state_next = HALT;
                end else begin
                    pc_next = pc_plus2;
                end
            end else begin
                valid_next = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, bubbles, stall, flush, HLT, wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    int passed = 0;
    int total  = 0;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .br_target    (br_target),
        .imem         (imem.master),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus2(ifid_pc_plus2),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        br_target = 16'h0000;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = 16'h0000;
        #12;
        total++; if (pc !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", pc); else passed++;
        total++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", ifid_valid); else passed++;
        total++; if (ifid_instr !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", ifid_instr); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
        total++; if (imem.imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem.imem_req); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        total++; if (imem.imem_req !== 1'b1) $display("FAIL post_reset_req got %b exp 1", imem.imem_req); else passed++;
    endtask

    task automatic test_stream();
        logic [15:0] exp_pp2;
        imem.imem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem.imem_rdata = 16'h1000 + 16'(i);
            exp_pp2 = 16'(2 * (i + 1));
            step();
            total++; if (ifid_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", i, ifid_valid); else passed++;
            total++; if (ifid_pc_plus2 !== exp_pp2) $display("FAIL stream_pp2[%0d] got %h exp %h", i, ifid_pc_plus2, exp_pp2); else passed++;
            total++; if (ifid_instr !== 16'h1000 + 16'(i)) $display("FAIL stream_instr[%0d] got %h exp %h", i, ifid_instr, 16'h1000 + 16'(i)); else passed++;
        end
        total++; if (pc !== 16'h0006) $display("FAIL stream_pc got %h exp 0006", pc); else passed++;
    endtask

    task automatic test_bubbles();
        flush = 1'b1;
        br_target = 16'h0010;
        step();
        flush = 1'b0;
        total++; if (imem.imem_req !== 1'b0) $display("FAIL redirect_req got %b exp 0", imem.imem_req); else passed++;
        total++; if (pc !== 16'h0010) $display("FAIL redirect_pc got %h exp 0010", pc); else passed++;
        step();
        imem.imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ifid_valid !== 1'b0) $display("FAIL bubble_valid[%0d] got %b exp 0", i, ifid_valid); else passed++;
            total++; if (imem.imem_addr !== 16'h0010) $display("FAIL bubble_addr[%0d] got %h exp 0010", i, imem.imem_addr); else passed++;
            total++; if (imem.imem_req !== 1'b1) $display("FAIL bubble_req[%0d] got %b exp 1", i, imem.imem_req); else passed++;
        end
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 16'h1111;
        step();
        total++; if (pc !== 16'h0012) $display("FAIL bubble_accept_pc got %h exp 0012", pc); else passed++;
        total++; if (ifid_valid !== 1'b1) $display("FAIL bubble_accept_valid got %b exp 1", ifid_valid); else passed++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        imem.imem_rdata = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc !== 16'h0012) $display("FAIL stall_pc[%0d] got %h exp 0012", i, pc); else passed++;
            total++; if (ifid_instr !== 16'h1111) $display("FAIL stall_instr[%0d] got %h exp 1111", i, ifid_instr); else passed++;
            total++; if (ifid_pc_plus2 !== 16'h0012) $display("FAIL stall_pp2[%0d] got %h exp 0012", i, ifid_pc_plus2); else passed++;
            total++; if (imem.imem_req !== 1'b1) $display("FAIL stall_req[%0d] got %b exp 1", i, imem.imem_req); else passed++;
        end
        stall = 1'b0;
        step();
        total++; if (ifid_instr !== 16'h2222) $display("FAIL unstall_instr got %h exp 2222", ifid_instr); else passed++;
        total++; if (ifid_pc_plus2 !== 16'h0014) $display("FAIL unstall_pp2 got %h exp 0014", ifid_pc_plus2); else passed++;
        total++; if (pc !== 16'h0014) $display("FAIL unstall_pc got %h exp 0014", pc); else passed++;
    endtask

    task automatic test_flush_stall();
        flush = 1'b1;
        stall = 1'b1;
        br_target = 16'h0100;
        step();
        flush = 1'b0;
        stall = 1'b0;
        total++; if (ifid_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", ifid_valid); else passed++;
        total++; if (ifid_instr !== 16'h0000) $display("FAIL flush_instr got %h exp 0000", ifid_instr); else passed++;
        total++; if (pc !== 16'h0100) $display("FAIL flush_pc got %h exp 0100", pc); else passed++;
        total++; if (imem.imem_req !== 1'b0) $display("FAIL flush_req got %b exp 0", imem.imem_req); else passed++;
        step();
        total++; if (imem.imem_req !== 1'b1) $display("FAIL refetch_req got %b exp 1", imem.imem_req); else passed++;
        total++; if (imem.imem_addr !== 16'h0100) $display("FAIL refetch_addr got %h exp 0100", imem.imem_addr); else passed++;
        total++; if (ifid_valid !== 1'b0) $display("FAIL refetch_bubble got %b exp 0", ifid_valid); else passed++;
        imem.imem_rdata = 16'h3333;
        step();
        total++; if (pc !== 16'h0102) $display("FAIL refetch_pc got %h exp 0102", pc); else passed++;
        total++; if (ifid_pc_plus2 !== 16'h0102) $display("FAIL refetch_pp2 got %h exp 0102", ifid_pc_plus2); else passed++;
    endtask

    task automatic test_halt();
        flush = 1'b1;
        br_target = 16'h0020;
        step();
        flush = 1'b0;
        step();
        imem.imem_rdata = 16'hF000;
        step();
        total++; if (ifid_instr !== 16'hF000) $display("FAIL hlt_instr got %h exp f000", ifid_instr); else passed++;
        total++; if (ifid_valid !== 1'b1) $display("FAIL hlt_valid got %b exp 1", ifid_valid); else passed++;
        total++; if (pc !== 16'h0020) $display("FAIL hlt_pc got %h exp 0020", pc); else passed++;
        total++; if (halted !== 1'b1) $display("FAIL hlt_halted got %b exp 1", halted); else passed++;
        total++; if (imem.imem_req !== 1'b0) $display("FAIL hlt_req got %b exp 0", imem.imem_req); else passed++;
        step();
        total++; if (ifid_valid !== 1'b0) $display("FAIL hlt_bubble got %b exp 0", ifid_valid); else passed++;
        total++; if (pc !== 16'h0020) $display("FAIL hlt_pc_frozen got %h exp 0020", pc); else passed++;
        total++; if (halted !== 1'b1) $display("FAIL hlt_still_halted got %b exp 1", halted); else passed++;
    endtask

    task automatic test_wrap_and_reset();
        flush = 1'b1;
        br_target = 16'hFFFE;
        step();
        flush = 1'b0;
        total++; if (halted !== 1'b0) $display("FAIL flush_exits_halt got %b exp 0", halted); else passed++;
        total++; if (pc !== 16'hFFFE) $display("FAIL wrap_target_pc got %h exp fffe", pc); else passed++;
        step();
        imem.imem_rdata = 16'h4444;
        step();
        total++; if (pc !== 16'h0000) $display("FAIL wrap_pc got %h exp 0000", pc); else passed++;
        total++; if (ifid_pc_plus2 !== 16'h0000) $display("FAIL wrap_pp2 got %h exp 0000", ifid_pc_plus2); else passed++;
        total++; if (ifid_valid !== 1'b1) $display("FAIL wrap_valid got %b exp 1", ifid_valid); else passed++;
        imem.imem_rdata = 16'h5555;
        step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (pc !== 16'h0000) $display("FAIL async_pc got %h exp 0000", pc); else passed++;
        total++; if (ifid_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", ifid_valid); else passed++;
        total++; if (ifid_instr !== 16'h0000) $display("FAIL async_instr got %h exp 0000", ifid_instr); else passed++;
        total++; if (ifid_pc_plus2 !== 16'h0000) $display("FAIL async_pp2 got %h exp 0000", ifid_pc_plus2); else passed++;
        total++; if (imem.imem_req !== 1'b0) $display("FAIL async_req got %b exp 0", imem.imem_req); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL async_halted got %b exp 0", halted); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubbles();
        test_stall();
        test_flush_stall();
        test_halt();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
